// File: rtl/note_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | note_pkg : note frequency table (C0..B8, centi-Hz) and divider helper |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package note_pkg;

  localparam int NUM_NOTES = 108;
  localparam logic [6:0] ALL_OFF = 7'd127;

  // Equal temperament, A4 (note 57) = 440 Hz, rounded to 0.01 Hz
  localparam int unsigned NOTE_CHZ [NUM_NOTES] = '{
      1635,   1732,   1835,   1945,   2060,   2183,   2312,   2450,   2596,   2750,   2914,   3087,
      3270,   3465,   3671,   3889,   4120,   4365,   4625,   4900,   5191,   5500,   5827,   6174,
      6541,   6930,   7342,   7778,   8241,   8731,   9250,   9800,  10383,  11000,  11654,  12347,
     13081,  13859,  14683,  15556,  16481,  17461,  18500,  19600,  20765,  22000,  23308,  24694,
     26163,  27718,  29366,  31113,  32963,  34923,  36999,  39200,  41530,  44000,  46616,  49388,
     52325,  55437,  58733,  62225,  65926,  69846,  73999,  78399,  83061,  88000,  93233,  98777,
    104650, 110873, 117466, 124451, 131851, 139691, 147998, 156798, 166122, 176000, 186466, 197553,
    209300, 221746, 234932, 248902, 263702, 279383, 295996, 313596, 332244, 352000, 372931, 395107,
    418601, 443492, 469864, 497803, 527404, 558765, 591991, 627193, 664488, 704000, 745862, 790213
  };

  function automatic int unsigned note_div(input logic [6:0] note, input int unsigned clk_hz);
    longint unsigned half;
    half = (64'(clk_hz) * 64'd100) / (64'd2 * 64'(NOTE_CHZ[note]));
    return 32'(half - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_voice.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | note_voice : one square-wave voice with reloadable half-period counter|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module note_voice #(
  parameter int DIV_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             tick,
  input  logic [6:0]       load_note,
  input  logic [DIV_W-1:0] load_div,
  input  logic [DIV_W-1:0] div,
  output logic             active,
  output logic [6:0]       note,
  output logic             sq
);

  logic             r_active;
  logic [6:0]       r_note;
  logic [DIV_W-1:0] r_cnt;
  logic             r_sq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_note   <= '0;
      r_cnt    <= '0;
      r_sq     <= 1'b0;
    end else if (clear) begin
      r_active <= 1'b0;
      r_note   <= '0;
      r_cnt    <= '0;
      r_sq     <= 1'b0;
    end else if (load) begin
      r_active <= 1'b1;
      r_note   <= load_note;
      r_cnt    <= load_div;
      r_sq     <= 1'b0;
    end else if (r_active && tick) begin
      if (r_cnt == '0) begin
        r_cnt <= div;
        r_sq  <= ~r_sq;
      end else begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
    end
  end

  assign active = r_active;
  assign note   = r_note;
  assign sq     = r_sq;

endmodule
`default_nettype wire

// File: rtl/poly_note_synth.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | poly_note_synth : polyphonic square-wave synth with 1-bit PWM mixer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module poly_note_synth
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ = 10_000_000,
  parameter int          VOICES = 4,
  parameter int          DIV_W  = 19
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_on,
  input  logic [6:0]                   cmd_note,
  output logic [VOICES-1:0]            voice_active,
  output logic [VOICES-1:0]            voice_sq,
  output logic [$clog2(VOICES+1)-1:0]  mix_level,
  output logic                         speaker
);

  localparam int MIX_W = $clog2(VOICES + 1);
  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  if ((VOICES < 1) || (VOICES > 8) ||
      (64'(note_div(7'd0, CLK_HZ)) >= (64'd1 << DIV_W))) begin : g_param_check
    $fatal(1, "poly_note_synth: VOICES out of range or DIV_W too small for C0");
  end

  logic             r_ready, r_cmd_vld, r_cmd_on;
  logic [6:0]       r_cmd_note;
  logic [IDX_W-1:0] r_steal;
  logic [MIX_W-1:0] r_mix, r_pwm_cnt;
  logic             r_speaker;

  logic [DIV_W-1:0] w_div_rom [NUM_NOTES];
  logic [6:0]       w_vnote   [VOICES];
  logic [DIV_W-1:0] w_vdiv    [VOICES];
  logic [VOICES-1:0] w_active, w_sq, w_match, w_load, w_clear;
  logic             w_do_on, w_do_off, w_all_off, w_any_match, w_any_idle, w_steal_adv;
  logic [IDX_W-1:0] w_idle_idx, w_target;
  logic [DIV_W-1:0] w_load_div;
  logic [MIX_W-1:0] w_pop;

  for (genvar n = 0; n < NUM_NOTES; n++) begin : g_rom
    assign w_div_rom[n] = DIV_W'(note_div(7'(n), CLK_HZ));
  end

  // Accepted commands are registered and applied to the voices one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready    <= 1'b0;
      r_cmd_vld  <= 1'b0;
      r_cmd_on   <= 1'b0;
      r_cmd_note <= '0;
    end else begin
      r_ready   <= 1'b1;
      r_cmd_vld <= cmd_valid & r_ready;
      if (cmd_valid && r_ready) begin
        r_cmd_on   <= cmd_on;
        r_cmd_note <= cmd_note;
      end
    end
  end

  always_comb begin
    w_do_on    = r_cmd_vld & r_cmd_on & (r_cmd_note < 7'(NUM_NOTES));
    w_do_off   = r_cmd_vld & ~r_cmd_on;
    w_all_off  = w_do_off & (r_cmd_note == ALL_OFF);
    w_match    = '0;
    w_load     = '0;
    w_clear    = '0;
    w_idle_idx = '0;
    for (int v = 0; v < VOICES; v++) begin
      w_match[v] = w_active[v] & (w_vnote[v] == r_cmd_note);
    end
    w_any_match = |w_match;
    w_any_idle  = ~&w_active;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (!w_active[v]) w_idle_idx = IDX_W'(v);
    end
    w_target    = w_any_idle ? w_idle_idx : r_steal;
    w_steal_adv = w_do_on & ~w_any_match & ~w_any_idle;
    w_load_div  = (r_cmd_note < 7'(NUM_NOTES)) ? w_div_rom[r_cmd_note] : '0;
    for (int v = 0; v < VOICES; v++) begin
      w_load[v]  = w_do_on & ~w_any_match & (w_target == IDX_W'(v));
      w_clear[v] = w_all_off | (w_do_off & w_match[v]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_steal <= '0;
    end else if (w_all_off) begin
      r_steal <= '0;
    end else if (w_steal_adv) begin
      r_steal <= (r_steal == IDX_W'(VOICES - 1)) ? '0 : r_steal + IDX_W'(1);
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    assign w_vdiv[v] = w_div_rom[w_vnote[v]];
    note_voice #(.DIV_W(DIV_W)) u_voice (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_load[v]),
      .clear     (w_clear[v]),
      .tick      (1'b1),
      .load_note (r_cmd_note),
      .load_div  (w_load_div),
      .div       (w_vdiv[v]),
      .active    (w_active[v]),
      .note      (w_vnote[v]),
      .sq        (w_sq[v])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int v = 0; v < VOICES; v++) begin
      w_pop = w_pop + MIX_W'(w_sq[v]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mix     <= '0;
      r_pwm_cnt <= '0;
      r_speaker <= 1'b0;
    end else begin
      r_mix     <= w_pop;
      r_pwm_cnt <= (r_pwm_cnt == MIX_W'(VOICES - 1)) ? '0 : r_pwm_cnt + MIX_W'(1);
      r_speaker <= (r_pwm_cnt < r_mix);
    end
  end

  assign cmd_ready    = r_ready;
  assign voice_active = w_active;
  assign voice_sq     = w_sq;
  assign mix_level    = r_mix;
  assign speaker      = r_speaker;

endmodule
`default_nettype wire

// File: tb/tb_poly_note_synth.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_poly_note_synth : directed bench for poly_note_synth (10 MHz, 4 v) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_poly_note_synth;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_on = 1'b0;
  logic [6:0] cmd_note = '0;
  logic       cmd_ready;
  logic [3:0] voice_active;
  logic [3:0] voice_sq;
  logic [2:0] mix_level;
  logic       speaker;

  int n_checks = 0;
  int n_fails  = 0;

  poly_note_synth #(.CLK_HZ(10_000_000), .VOICES(4), .DIV_W(19)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_on       (cmd_on),
    .cmd_note     (cmd_note),
    .voice_active (voice_active),
    .voice_sq     (voice_sq),
    .mix_level    (mix_level),
    .speaker      (speaker)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic on, input logic [6:0] note);
    cmd_valid = 1'b1;
    cmd_on    = on;
    cmd_note  = note;
    step(1);
    cmd_valid = 1'b0;
  endtask

  // Cycles until voice_sq[idx] changes, bounded
  task automatic half_period(input logic [1:0] idx, output int cycles);
    logic start;
    start  = voice_sq[idx];
    cycles = 0;
    while (voice_sq[idx] == start && cycles < 20000) begin
      step(1);
      cycles++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int hi;

    step(2);
    chk("reset_outputs", 32'({voice_active, voice_sq, mix_level, speaker, cmd_ready}), 32'd0);
    rst_n = 1'b1;
    #2;
    chk("ready_before_clk", 32'(cmd_ready), 32'd0);
    step(1);
    chk("ready_after_clk", 32'(cmd_ready), 32'd1);

    // single voice, A4 = note 57, half-period 11363
    send(1'b1, 7'd57);
    chk("on57_latency", 32'(voice_active), 32'd0);
    step(1);
    chk("on57_active", 32'(voice_active), 32'b0001);
    half_period(2'd0, c);
    chk("a4_rise", c, 11363);
    chk("mix_lags_sq", 32'(mix_level), 32'd0);
    step(1);
    chk("mix_follows_sq", 32'(mix_level), 32'd1);
    half_period(2'd0, c);
    chk("a4_fall", c + 1, 11363);

    send(1'b0, 7'd127);
    step(1);

    // four voices in order, A5 = note 69 on voice1, half-period 5681
    send(1'b1, 7'd57);
    send(1'b1, 7'd69);
    send(1'b1, 7'd60);
    send(1'b1, 7'd64);
    step(1);
    chk("four_voices", 32'(voice_active), 32'b1111);
    half_period(2'd1, c);
    chk("v1_sync", 32'(c <= 5681), 32'd1);
    half_period(2'd1, c);
    chk("a5_half", c, 5681);
    send(1'b1, 7'd69);
    half_period(2'd1, c);
    chk("retrig_phase", c + 1, 5681);
    chk("retrig_active", 32'(voice_active), 32'b1111);

    // note-off
    send(1'b0, 7'd69);
    chk("off_latency", 32'(voice_active), 32'b1111);
    step(1);
    chk("off69_active", 32'(voice_active), 32'b1101);
    chk("off69_sq", 32'(voice_sq[1]), 32'd0);
    send(1'b0, 7'd100);
    step(1);
    chk("off100_nochange", 32'(voice_active), 32'b1101);
    send(1'b1, 7'd69);
    step(1);
    chk("refill_idle", 32'(voice_active), 32'b1111);

    // stealing: note 72 half 4777 onto voice0, note 76 half 3792 onto voice1
    send(1'b1, 7'd72);
    step(1);
    chk("steal5_sq0", 32'(voice_sq[0]), 32'd0);
    half_period(2'd0, c);
    chk("steal5_v0", c, 4777);
    send(1'b1, 7'd76);
    step(1);
    chk("steal6_sq1", 32'(voice_sq[1]), 32'd0);
    half_period(2'd1, c);
    chk("steal6_v1", c, 3792);

    send(1'b0, 7'd127);
    step(3);
    chk("alloff_active", 32'(voice_active), 32'd0);
    chk("alloff_mix", 32'(mix_level), 32'd0);
    chk("alloff_speaker", 32'(speaker), 32'd0);

    send(1'b1, 7'd108);
    step(1);
    chk("on108_ignored", 32'(voice_active), 32'd0);

    // notes 107 (half 632) and 106 (half 670) overlap high from ~672 to 1264 cycles
    send(1'b1, 7'd107);
    send(1'b1, 7'd106);
    step(700);
    chk("mix_two", 32'(mix_level), 32'd2);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      hi += int'(speaker);
      step(1);
    end
    chk("pwm_half_duty", hi, 4);

    // asynchronous reset mid-tone
    rst_n = 1'b0;
    #1;
    chk("reset_async", 32'({voice_active, voice_sq, mix_level, speaker, cmd_ready}), 32'd0);
    step(1);
    #2;
    rst_n = 1'b1;
    step(1);
    chk("ready_after_rerelease", 32'(cmd_ready), 32'd1);
    chk("idle_after_reset", 32'(voice_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
